// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states, buffered entry layout,
// and the PC reset value.
package fetch_pkg;

    localparam int unsigned QU_PC_WIDTH    = 32;
    localparam int unsigned QU_INSTR_WIDTH = 32;

    localparam logic [QU_PC_WIDTH-1:0] QU_PC_RESET_VAL = '0;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [QU_PC_WIDTH-1:0]    pc;
        logic [QU_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with a flush input and asynchronous active-low reset.
// DEPTH must be a power of two, at least 2.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data_c,
    output logic                   empty_c,
    output logic                   full_c,
    output logic [$clog2(DEPTH):0] count_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign count_c    = wr_ptr_q - rd_ptr_q;
    assign empty_c    = (wr_ptr_q == rd_ptr_q);
    assign full_c     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_push    = push && !full_c && !flush;
    assign do_pop     = pop && !empty_c && !flush;
    assign pop_data_c = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the PC counter, issues in-order imem reads under credit and
// buffers {pc, instr} for decode. Define INSTR_FETCH_PERF_EN to add performance counters.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH        = QU_PC_WIDTH,
    parameter int unsigned INSTR_WIDTH     = QU_INSTR_WIDTH,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc_cur,
    output logic                   pc_en,
    output logic                   pc_override,
    output logic [PC_WIDTH-1:0]    pc_target,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [PC_WIDTH-1:0]    instr_pc
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_drop_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;
    localparam int unsigned EW = PC_WIDTH + INSTR_WIDTH;

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic [OW-1:0]       outstanding_q;
    logic [OW-1:0]       drop_cnt_q;
    logic [OW-1:0]       drop_next_c;
    logic                credit_ok_c;
    logic                fire_c;
    logic                rsp_acc_c;
    logic                buf_push_c;
    logic                buf_pop_c;

    logic [EW-1:0]       buf_head_c;
    logic                buf_empty_c;
    logic                buf_full_unused;
    logic [CW-1:0]       buf_count_c;
    logic [PC_WIDTH-1:0] pcq_head_c;
    logic                pcq_empty_unused;
    logic                pcq_full_unused;
    logic [OW-1:0]       pcq_count_unused;

    // Responses only count while something is in flight; stale post-reset data is ignored.
    assign rsp_acc_c   = imem_rsp_valid && (outstanding_q != '0);
    assign credit_ok_c = ((SW'(outstanding_q) + SW'(buf_count_c)) < SW'(FIFO_DEPTH))
                         && (outstanding_q < OW'(MAX_OUTSTANDING));
    assign drop_next_c = outstanding_q - OW'(rsp_acc_c);
    assign fire_c      = imem_req_valid && imem_req_ready;
    assign buf_pop_c   = instr_valid && instr_ready;
    assign imem_req_addr = pc_cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= INIT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    state_d = RUN;
            RUN:     state_d = RUN;
            DRAIN:   if (rsp_acc_c && (drop_cnt_q == OW'(1))) state_d = RUN;
            default: state_d = INIT;
        endcase
        if (redirect_valid) state_d = (drop_next_c != '0) ? DRAIN : RUN;
    end

    always_comb begin
        imem_req_valid = 1'b0;
        pc_en          = 1'b0;
        pc_override    = 1'b0;
        pc_target      = PC_WIDTH'(QU_PC_RESET_VAL);
        buf_push_c     = 1'b0;
        if (state_q == RUN) begin
            imem_req_valid = credit_ok_c && !redirect_valid;
            buf_push_c     = rsp_acc_c && !redirect_valid;
        end
        pc_en = imem_req_valid && imem_req_ready;
        if (redirect_valid) begin
            pc_override = 1'b1;
            pc_target   = redirect_pc;
        end
    end

    // In-flight and to-be-discarded response counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_q + OW'(fire_c) - OW'(rsp_acc_c);
            if (redirect_valid)
                drop_cnt_q <= drop_next_c;
            else if ((state_q == DRAIN) && rsp_acc_c)
                drop_cnt_q <= drop_cnt_q - OW'(1);
        end
    end

    fetch_fifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (1'b0),
        .push       (fire_c),
        .push_data  (pc_cur),
        .pop        (rsp_acc_c),
        .pop_data_c (pcq_head_c),
        .empty_c    (pcq_empty_unused),
        .full_c     (pcq_full_unused),
        .count_c    (pcq_count_unused)
    );

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (buf_push_c),
        .push_data  ({pcq_head_c, imem_rsp_data}),
        .pop        (buf_pop_c),
        .pop_data_c (buf_head_c),
        .empty_c    (buf_empty_c),
        .full_c     (buf_full_unused),
        .count_c    (buf_count_c)
    );

    assign instr_valid = !buf_empty_c;
    assign instr_data  = buf_empty_c ? '0 : buf_head_c[INSTR_WIDTH-1:0];
    assign instr_pc    = buf_empty_c ? '0 : buf_head_c[EW-1:INSTR_WIDTH];

`ifdef INSTR_FETCH_PERF_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fire_c)                  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (rsp_acc_c && !buf_push_c) perf_drop_cnt <= perf_drop_cnt + 32'd1;
            if ((state_q == RUN) && !credit_ok_c) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
